// File: rtl/scoreboard_regfile.sv
// -----------------------------------------------------------------------------
// scoreboard_regfile
//   Register file with two combinational read ports and one writeback port,
//   plus a per-register "pending write" scoreboard used by an issue stage to
//   detect RAW (busyN) and WAW (waw_hit) hazards.
//
// Parameters
//   DATA_W   : width of each register
//   ADDR_W   : register address width, depth = 2**ADDR_W
//   BYPASS   : 1 = a same-cycle writeback is forwarded to the read ports
//   ZERO_REG : 1 = register 0 is hardwired to zero and never becomes busy
//
// Ports
//   clk                : single clock, all state changes on the rising edge
//   rst                : synchronous active-high reset
//   rd_addr1/rd_addr2  : read addresses
//   rd_data1/rd_data2  : read data (combinational)
//   busy1/busy2        : pending-write status of the addressed registers
//   wr_en/wr_addr/wr_data : writeback strobe, address and data
//   iss_en/iss_addr    : issue strobe and destination register to mark pending
//   waw_hit            : issue targets a register that is already pending
//   busy_cnt           : number of pending registers (registered)
// -----------------------------------------------------------------------------
module scoreboard_regfile #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              waw_hit,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int              DEPTH    = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] regFile_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [ADDR_W:0]   busyCnt_r;

  logic              wrEff_s;
  logic              issEff_s;
  logic              cntInc_s;
  logic              cntDec_s;
  logic [DEPTH-1:0]  busyNext_s;

  logic [ADDR_W-1:0] rdAddr_s [2];
  logic [DATA_W-1:0] rdData_s [2];
  logic              rdBusy_s [2];

  assign rdAddr_s[0] = rd_addr1;
  assign rdAddr_s[1] = rd_addr2;
  assign rd_data1    = rdData_s[0];
  assign rd_data2    = rdData_s[1];
  assign busy1       = rdBusy_s[0];
  assign busy2       = rdBusy_s[1];
  assign busy_cnt    = busyCnt_r;

  // Qualify write/issue strobes: the hardwired zero register absorbs both.
  always_comb begin
    wrEff_s  = 1'b0;
    issEff_s = 1'b0;
    if (ZERO_REG && (wr_addr == ZERO_IDX)) begin
      wrEff_s = 1'b0;
    end else begin
      wrEff_s = wr_en;
    end
    if (ZERO_REG && (iss_addr == ZERO_IDX)) begin
      issEff_s = 1'b0;
    end else begin
      issEff_s = iss_en;
    end
  end

  // Next busy vector and counter step; the issue is applied after the clear
  // so a same-address issue+writeback leaves the register pending.
  always_comb begin
    busyNext_s = busy_r;
    if (wrEff_s) begin
      busyNext_s[wr_addr] = 1'b0;
    end else begin
      busyNext_s = busy_r;
    end
    if (issEff_s) begin
      busyNext_s[iss_addr] = 1'b1;
    end else begin
      busyNext_s[iss_addr] = busyNext_s[iss_addr];
    end
    // Only a 0->1 transition counts up; re-issue of a busy register is net 0.
    cntInc_s = issEff_s && !busy_r[iss_addr];
    // A clear is cancelled when the same register is re-issued this cycle.
    cntDec_s = wrEff_s && busy_r[wr_addr] &&
               !(issEff_s && (iss_addr == wr_addr));
  end

  // Register array, scoreboard bits and pending counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 32'sd0; i < DEPTH; i++) begin
        regFile_r[i] <= {DATA_W{1'b0}};
      end
      busy_r    <= {DEPTH{1'b0}};
      busyCnt_r <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wrEff_s) begin
        regFile_r[wr_addr] <= wr_data;
      end
      busy_r <= busyNext_s;
      case ({cntInc_s, cntDec_s})
        2'b10:   busyCnt_r <= busyCnt_r + CNT_ONE;
        2'b01:   busyCnt_r <= busyCnt_r - CNT_ONE;
        default: busyCnt_r <= busyCnt_r;
      endcase
    end
  end

  // Read ports: zero register first, then forwarding (still active during
  // reset), then reset masking, then the stored state.
  always_comb begin
    for (int p = 32'sd0; p < 32'sd2; p++) begin
      rdData_s[p] = {DATA_W{1'b0}};
      rdBusy_s[p] = 1'b0;
      if (ZERO_REG && (rdAddr_s[p] == ZERO_IDX)) begin
        rdData_s[p] = {DATA_W{1'b0}};
        rdBusy_s[p] = 1'b0;
      end else if (BYPASS && wr_en && (wr_addr == rdAddr_s[p])) begin
        // The value is arriving now, so the consumer need not wait for it.
        rdData_s[p] = wr_data;
        rdBusy_s[p] = 1'b0;
      end else if (rst) begin
        rdData_s[p] = {DATA_W{1'b0}};
        rdBusy_s[p] = 1'b0;
      end else begin
        rdData_s[p] = regFile_r[rdAddr_s[p]];
        rdBusy_s[p] = busy_r[rdAddr_s[p]];
      end
    end
  end

  // WAW detect against the current scoreboard; suppressed while in reset.
  always_comb begin
    waw_hit = 1'b0;
    if (rst) begin
      waw_hit = 1'b0;
    end else begin
      waw_hit = issEff_s && busy_r[iss_addr];
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
module tb_scoreboard_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr, iss_addr;
  logic [15:0] wr_data;
  logic        wr_en, iss_en;

  logic [15:0] rdData1, rdData2, nbRdData1, nbRdData2;
  logic        busy1, busy2, nbBusy1, nbBusy2, wawHit, nbWawHit;
  logic [4:0]  busyCnt, nbBusyCnt;

  always #5 clk = ~clk;

  scoreboard_regfile dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rdData1), .rd_data2(rdData2),
    .busy1(busy1), .busy2(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .waw_hit(wawHit), .busy_cnt(busyCnt)
  );

  // Same stimulus, forwarding disabled.
  scoreboard_regfile #(.BYPASS(1'b0)) dutNb (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nbRdData1), .rd_data2(nbRdData2),
    .busy1(nbBusy1), .busy2(nbBusy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .waw_hit(nbWawHit), .busy_cnt(nbBusyCnt)
  );

  typedef struct {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] d2nb;
    logic        b1;
    logic        b2;
    logic        waw;
    logic [4:0]  cnt;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    vectors = 0;
  int    compares = 0;
  int    miscompares = 0;

  task automatic chk(input string nm, input string fld,
                     input logic [15:0] act, input logic [15:0] exp);
    compares++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; pop one expectation per cycle.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      exp_t  e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      vectors++;
      chk(n, "rd_data1", rdData1, e.d1);
      chk(n, "rd_data2", rdData2, e.d2);
      chk(n, "nb_rd_data2", nbRdData2, e.d2nb);
      chk(n, "busy1", {15'd0, busy1}, {15'd0, e.b1});
      chk(n, "busy2", {15'd0, busy2}, {15'd0, e.b2});
      chk(n, "waw_hit", {15'd0, wawHit}, {15'd0, e.waw});
      chk(n, "busy_cnt", {11'd0, busyCnt}, {11'd0, e.cnt});
    end
  end

  task automatic vec(input string nm, input logic r,
                     input logic we, input logic [3:0] wa, input logic [15:0] wd,
                     input logic ie, input logic [3:0] ia,
                     input logic [3:0] ra1, input logic [3:0] ra2,
                     input logic [15:0] d1, input logic [15:0] d2,
                     input logic [15:0] d2nb, input logic b1, input logic b2,
                     input logic waw, input logic [4:0] cnt);
    exp_t e;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; rd_addr1 = ra1; rd_addr2 = ra2;
    e.d1 = d1; e.d2 = d2; e.d2nb = d2nb; e.b1 = b1; e.b2 = b2;
    e.waw = waw; e.cnt = cnt;
    expQ.push_back(e);
    nameQ.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] regVal(input int i);
    case (i)
      2:       return 16'h0022;
      3:       return 16'hBEEF;
      5:       return 16'h1234;
      7:       return 16'h7777;
      default: return 16'h0000;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0;
    iss_en = 1'b0; iss_addr = 4'd0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    //   name        rst we wa    wd        ie  ia    ra1   ra2   d1        d2        d2nb      b1    b2    waw   cnt
    vec("rst_hold",  1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd5, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("wr_r3",     1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd3, 4'd5, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("rd_r3",     1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("byp_r5",    1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 4'd3, 4'd5, 16'hBEEF, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("rd_r5",     1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd5, 4'd5, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("wr_iss_r0", 1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("rd_r0",     1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("iss_r7",    1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd3, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("reiss_r7",  1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd7, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 5'd1);
    vec("wr_r7",     1'b0, 1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 4'd7, 4'd3, 16'h7777, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 5'd1);
    vec("after_r7",  1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd2, 16'h7777, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("iss_r2",    1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 4'd2, 4'd7, 16'h0000, 16'h7777, 16'h7777, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("iss_wr_r2", 1'b0, 1'b1, 4'd2, 16'h2222, 1'b1, 4'd2, 4'd2, 4'd4, 16'h2222, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd1);
    vec("chk_r2",    1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd2, 4'd2, 16'h2222, 16'h2222, 16'h2222, 1'b1, 1'b1, 1'b0, 5'd1);
    vec("wr2_iss9",  1'b0, 1'b1, 4'd2, 16'h0022, 1'b1, 4'd9, 4'd9, 4'd2, 16'h0000, 16'h0022, 16'h2222, 1'b0, 1'b0, 1'b0, 5'd1);
    vec("chk_net",   1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd2, 16'h0000, 16'h0022, 16'h0022, 1'b1, 1'b0, 1'b0, 5'd1);
    // Issue R1..R15 with R9 already pending from above.
    for (int i = 1; i <= 15; i++) begin
      vec($sformatf("iss_r%0d", i), 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'(i),
          4'(i), 4'd0, regVal(i), 16'h0000, 16'h0000,
          (i == 9), 1'b0, (i == 9), (i <= 9) ? 5'(i) : 5'(i - 1));
    end
    vec("cnt15",     1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd15, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd15);
    vec("rst_mid",   1'b1, 1'b1, 4'd4, 16'h4444, 1'b1, 4'd6, 4'd4, 4'd3, 16'h4444, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd15);
    vec("post_rst",  1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("post_rst2", 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd15, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0);
    vec("resume",    1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd5, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd1);
    @(negedge clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
